// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator.
// Turns a valid/ready command stream into one Wishbone read or write per
// command and returns a response carrying read data and error/timeout status.
module wb_host_master #(
   parameter  int unsigned ADDR_W  = 32,
   parameter  int unsigned DATA_W  = 32,
   parameter  int unsigned TIMEOUT = 255,
   localparam int unsigned SEL_W   = DATA_W / 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [SEL_W-1:0]  cmd_sel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [SEL_W-1:0]  wbm_sel_o,
   output logic [ADDR_W-1:0] wbm_adr_o,
   output logic [DATA_W-1:0] wbm_dat_o,
   input  logic [DATA_W-1:0] wbm_dat_i,
   input  logic              wbm_ack_i,
   input  logic              wbm_err_i
);

   // A zero TIMEOUT still needs a legal one-bit counter; it is simply never compared.
   localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             timed_out;
   logic             accept;
   logic             consume;

   assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);
   assign accept    = (state == IDLE) && cmd_valid;
   assign consume   = (state == RESP) && rsp_ready;

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state decode; ERR beats ACK, and either beats the timeout
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (cmd_valid) state_next = BUS;
         BUS:     if (wbm_ack_i || wbm_err_i || timed_out) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake and bus strobes decoded from the registered state
   always_comb begin
      cmd_ready = (state == IDLE);
      wbm_cyc_o = (state == BUS);
      wbm_stb_o = (state == BUS);
      rsp_valid = (state == RESP);
   end

   // Registered bus request, response fields and timeout counter
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbm_we_o    <= 1'b0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
         wbm_sel_o   <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         cnt         <= '0;
      end else begin
         if (accept) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_addr;
            wbm_dat_o <= cmd_data;
            wbm_sel_o <= cmd_sel;
            cnt       <= '0;
         end
         if (state == BUS) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (wbm_err_i) begin
               rsp_data    <= '0;
               rsp_err     <= 1'b1;
               rsp_timeout <= 1'b0;
            end else if (wbm_ack_i) begin
               rsp_data    <= wbm_we_o ? '0 : wbm_dat_i;
               rsp_err     <= 1'b0;
               rsp_timeout <= 1'b0;
            end else if (timed_out) begin
               rsp_data    <= '0;
               rsp_err     <= 1'b1;
               rsp_timeout <= 1'b1;
            end
         end
         if (consume) begin
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
         end
      end
   end

endmodule
